// File: rtl/cskipa_pipe_if.sv
// Operand/result handshake bundle for the pipelined carry-skip adder.
// master drives operands and consumes results; slave is the adder.
interface cskipa_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   out0;

   modport master (
      output in_valid, in0, in1, cin, out_ready,
      input  in_ready, out_valid, out0
   );

   modport slave (
      input  in_valid, in0, in1, cin, out_ready,
      output in_ready, out_valid, out0
   );
endinterface

// File: rtl/cskipa_pipe.sv
// Pipelined carry-skip adder: WIDTH bits in BLOCK-bit skip blocks,
// spread over STAGES registers, optional OR-approximated low bits.
module cskipa_pipe #(
   parameter int WIDTH      = 16,
   parameter int BLOCK      = 4,
   parameter int STAGES     = 2,
   parameter int APPROX_LSB = 0
) (
   input logic         clk,
   input logic         rst_n,
   cskipa_pipe_if.slave bus
);
   localparam int NB = WIDTH / BLOCK;

   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] s_q [STAGES];
   logic             c_q [STAGES];
   logic             v_q [STAGES];

   logic [WIDTH-1:0] a_d [STAGES];
   logic [WIDTH-1:0] b_d [STAGES];
   logic [WIDTH-1:0] s_d [STAGES];
   logic             c_d [STAGES];
   logic             v_d [STAGES];

   logic adv;

   assign adv = !v_q[STAGES-1] || bus.out_ready;

   assign bus.in_ready  = adv;
   assign bus.out_valid = v_q[STAGES-1];
   assign bus.out0      = {c_q[STAGES-1], s_q[STAGES-1]};

   // Operands are fully consumed by the last stage.
   logic unused_ops;
   assign unused_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};

   always_comb begin
      logic [WIDTH-1:0] sa, sb, s;
      logic             sc, sv, c, rc, allp, p, g, ex;
      int               i;
      sa   = '0;
      sb   = '0;
      s    = '0;
      sc   = 1'b0;
      sv   = 1'b0;
      c    = 1'b0;
      rc   = 1'b0;
      allp = 1'b0;
      p    = 1'b0;
      g    = 1'b0;
      ex   = 1'b0;
      i    = 0;
      for (int k = 0; k < STAGES; k++) begin
         if (k == 0) begin
            sa = bus.in0;
            sb = bus.in1;
            s  = '0;
            sc = bus.cin;
            sv = bus.in_valid;
         end else begin
            sa = a_q[k-1];
            sb = b_q[k-1];
            s  = s_q[k-1];
            sc = c_q[k-1];
            sv = v_q[k-1];
         end
         c = sc;
         for (int j = k*NB/STAGES; j < (k+1)*NB/STAGES; j++) begin
            rc   = c;
            allp = 1'b1;
            for (int t = 0; t < BLOCK; t++) begin
               i  = j*BLOCK + t;
               ex = (i >= APPROX_LSB);
               // Approximate bits neither propagate nor generate.
               p    = (sa[i] ^ sb[i]) & ex;
               g    = sa[i] & sb[i] & ex;
               s[i] = ex ? (p ^ rc) : (sa[i] | sb[i]);
               rc   = g | (p & rc);
               allp = allp & p;
            end
            c = allp ? c : rc;
         end
         a_d[k] = sa;
         b_d[k] = sb;
         s_d[k] = s;
         c_d[k] = c;
         v_d[k] = sv;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
            v_q[k] <= 1'b0;
         end
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
            c_q[k] <= c_d[k];
            v_q[k] <= v_d[k];
         end
      end
   end
endmodule

// File: tb/tb_cskipa_pipe.sv
// Scoreboard bench: exact and APPROX_LSB=4 builds driven in lockstep,
// expected sums queued on acceptance and checked on output.
module tb_cskipa_pipe;
   localparam int W  = 16;
   localparam int ST = 2;
   localparam int L  = 4;

   typedef struct {
      logic [W:0] ex;
      logic [W:0] ap;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cskipa_pipe_if #(.WIDTH(W)) ife ();
   cskipa_pipe_if #(.WIDTH(W)) ifa ();

   assign ifa.in_valid  = ife.in_valid;
   assign ifa.in0       = ife.in0;
   assign ifa.in1       = ife.in1;
   assign ifa.cin       = ife.cin;
   assign ifa.out_ready = ife.out_ready;

   cskipa_pipe #(
      .WIDTH(W), .BLOCK(4), .STAGES(ST), .APPROX_LSB(0)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(ife)
   );

   cskipa_pipe #(
      .WIDTH(W), .BLOCK(4), .STAGES(ST), .APPROX_LSB(L)
   ) u_apx (
      .clk(clk), .rst_n(rst_n), .bus(ifa)
   );

   exp_t q[$];
   int   n_run = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   n_out = 0;
   bit   lat_on = 1'b0;
   bit   snd_done;
   bit   rnd_done;

   function automatic logic [W:0] model(
      logic [W-1:0] a, logic [W-1:0] b, logic c, int l);
      logic [W:0] lo, hi, m;
      if (l == 0)
         return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      m  = ({{W{1'b0}}, 1'b1} << l) - 1'b1;
      lo = {1'b0, a | b} & m;
      hi = (({1'b0, a} >> l) + ({1'b0, b} >> l)) << l;
      return hi | lo;
   endfunction

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (rst_n && ife.out_valid && ife.out_ready) begin
         n_out++;
         if (q.size() == 0) begin
            chk("spurious_vld", 64'(ife.out_valid), 0);
         end else begin
            e = q.pop_front();
            chk("sum", 64'(ife.out0), 64'(e.ex));
            chk("apx_vld", 64'(ifa.out_valid), 1);
            chk("apx_sum", 64'(ifa.out0), 64'(e.ap));
            if (lat_on) chk("latency", 64'(cyc - e.cyc), ST);
         end
      end
      if (rst_n && ife.in_valid && ife.in_ready) begin
         e.ex  = model(ife.in0, ife.in1, ife.cin, 0);
         e.ap  = model(ife.in0, ife.in1, ife.cin, L);
         e.cyc = cyc;
         q.push_back(e);
      end
   end

   // Called just after a rising edge; returns just after the accept edge.
   task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic c);
      int n;
      ife.in0      = a;
      ife.in1      = b;
      ife.cin      = c;
      ife.in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ife.in_ready && n < 200);
      if (!ife.in_ready) chk("accept_to", 64'(ife.in_ready), 1);
      @(posedge clk);
      #1;
      ife.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("drain", 64'(q.size()), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int base;
      rst_n         = 1'b0;
      ife.in_valid  = 1'b0;
      ife.out_ready = 1'b1;
      ife.in0       = '0;
      ife.in1       = '0;
      ife.cin       = 1'b0;

      repeat (3) begin
         @(posedge clk);
         #1;
         ife.in0       = W'($urandom);
         ife.in1       = W'($urandom);
         ife.cin       = 1'($urandom);
         ife.in_valid  = 1'($urandom);
         ife.out_ready = 1'($urandom);
         @(negedge clk);
         chk("rst_vld", 64'(ife.out_valid), 0);
         chk("rst_out0", 64'(ife.out0), 0);
         chk("rst_rdy", 64'(ife.in_ready), 1);
      end
      @(posedge clk);
      #1;
      ife.in_valid  = 1'b0;
      ife.out_ready = 1'b1;
      rst_n         = 1'b1;
      @(negedge clk);
      chk("rel_vld", 64'(ife.out_valid), 0);
      chk("rel_rdy", 64'(ife.in_ready), 1);
      @(posedge clk);
      #1;

      lat_on = 1'b1;
      send(16'hFFFF, 16'h0001, 1'b0);
      send(16'hFFFF, 16'h0000, 1'b1);
      drain();

      send(16'h0001, 16'h0002, 1'b0);
      send(16'h8000, 16'h8000, 1'b0);
      send(16'h1234, 16'h4321, 1'b1);
      drain();

      send(16'h000F, 16'h0001, 1'b1);
      send(16'h00F0, 16'h0010, 1'b0);
      send(16'hFFFF, 16'hFFFF, 1'b1);
      send(16'h0000, 16'h0000, 1'b0);
      drain();

      lat_on        = 1'b0;
      base          = n_out;
      snd_done      = 1'b0;
      ife.out_ready = 1'b0;
      fork
         begin
            send(16'h0011, 16'h0022, 1'b0);
            send(16'hF00F, 16'h0FF1, 1'b0);
            send(16'h7FFF, 16'h0001, 1'b1);
            snd_done = 1'b1;
         end
      join_none
      repeat (2) @(negedge clk);
      repeat (4) begin
         @(negedge clk);
         chk("bp_rdy", 64'(ife.in_ready), 0);
         chk("bp_vld", 64'(ife.out_valid), 1);
         chk("bp_hold", 64'(ife.out0), 64'(17'h00033));
      end
      @(posedge clk);
      #1;
      ife.out_ready = 1'b1;
      for (int n = 0; n < 200 && !snd_done; n++) @(posedge clk);
      chk("bp_sent", 64'(snd_done), 1);
      #1;
      drain();
      chk("bp_count", 64'(n_out - base), 3);

      rnd_done = 1'b0;
      fork
         begin
            for (int n = 0; n < 300; n++)
               send(W'($urandom), W'($urandom), 1'($urandom));
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #2;
               ife.out_ready = 1'($urandom);
            end
         end
      join
      ife.out_ready = 1'b1;
      drain();

      send(16'h0101, 16'h0202, 1'b0);
      send(16'h0303, 16'h0404, 1'b1);
      chk("mr_pre", 64'(ife.out_valid), 1);
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("mr_vld", 64'(ife.out_valid), 0);
      chk("mr_out0", 64'(ife.out0), 0);
      #1;
      rst_n = 1'b1;
      base  = n_out;
      repeat (6) @(negedge clk);
      chk("mr_none", 64'(n_out - base), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
